// File: rtl/pfa_seq_ctrl_pkg.sv
// Shared widths, FSM state type and factor configuration for the PFA index sequencer.
package pfa_seq_ctrl_pkg;

   localparam int unsigned IDX_W = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0] n1;
      logic [IDX_W-1:0] n2;
      logic [IDX_W-1:0] n3;
   } fac_cfg_t;

endpackage

// File: rtl/pfa_idx_cnt.sv
// Wrapping index counter: counts 0..limit-1 on inc, flags wrap on the carry-out step.
module pfa_idx_cnt #(
   parameter int unsigned IDX_W = pfa_seq_ctrl_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic [IDX_W-1:0] limit,
   output logic [IDX_W-1:0] count,
   output logic             wrap
);

   logic at_max_c;

   // A limit of 1 makes every increment a wrap, so the count stays at 0.
   assign at_max_c = (count == (limit - IDX_W'(1)));
   assign wrap     = inc && at_max_c;

   // Count register; clear wins over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= at_max_c ? '0 : (count + IDX_W'(1));
      end
   end

endmodule

// File: rtl/pfa_seq_ctrl.sv
// PFA index sequencer: walks (n1,n2,n3) over N1 x N2 x N3 with a valid/ready handshake.
module pfa_seq_ctrl #(
   parameter int unsigned IDX_W = pfa_seq_ctrl_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             mode,
   input  logic             ext_step,
   input  logic [IDX_W-1:0] cfg_n1,
   input  logic [IDX_W-1:0] cfg_n2,
   input  logic [IDX_W-1:0] cfg_n3,
   input  logic             idx_ready,
   output logic             idx_valid,
   output logic [IDX_W-1:0] n1_out,
   output logic [IDX_W-1:0] n2_out,
   output logic [IDX_W-1:0] n3_out,
   output logic             idx_last,
   output logic             wrap1,
   output logic             wrap2,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);

   import pfa_seq_ctrl_pkg::*;

   localparam int unsigned CFG_W = $bits(fac_cfg_t) / 3;

   state_t   state;
   state_t   state_nx;
   fac_cfg_t fac;
   logic     load_c;
   logic     err_c;
   logic     cfg_zero_c;
   logic     xfer_c;
   logic     clr_c;
   logic     wrap3_c;
   logic     last_c;

   assign cfg_zero_c = (cfg_n1 == '0) || (cfg_n2 == '0) || (cfg_n3 == '0);

   // A step is taken only on a handshake (plus ext_step in gated mode); abort cancels it.
   assign xfer_c = idx_valid && idx_ready && (!mode || ext_step) && !abort;

   // Counters restart from zero on abort and while loading a new configuration.
   assign clr_c = abort || (state == ST_LOAD);

   // Final tuple: every counter at its factor minus one.
   assign last_c   = (n1_out == (IDX_W'(fac.n1) - IDX_W'(1))) &&
                     (n2_out == (IDX_W'(fac.n2) - IDX_W'(1))) &&
                     (n3_out == (IDX_W'(fac.n3) - IDX_W'(1)));
   assign idx_last = idx_valid && last_c;

   pfa_idx_cnt #(.IDX_W(IDX_W)) u_cnt1 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_c),
      .inc   (xfer_c),
      .limit (IDX_W'(fac.n1)),
      .count (n1_out),
      .wrap  (wrap1)
   );

   pfa_idx_cnt #(.IDX_W(IDX_W)) u_cnt2 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_c),
      .inc   (wrap1),
      .limit (IDX_W'(fac.n2)),
      .count (n2_out),
      .wrap  (wrap2)
   );

   // Carry out of the outermost counter is exactly the transfer of the final tuple.
   pfa_idx_cnt #(.IDX_W(IDX_W)) u_cnt3 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_c),
      .inc   (wrap2),
      .limit (IDX_W'(fac.n3)),
      .count (n3_out),
      .wrap  (wrap3_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; abort overrides everything else.
   always_comb begin
      state_nx = state;
      load_c   = 1'b0;
      err_c    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (cfg_zero_c) begin
                  err_c = 1'b1;
               end else begin
                  state_nx = ST_LOAD;
                  load_c   = 1'b1;
               end
            end
         end
         ST_LOAD: state_nx = ST_RUN;
         ST_RUN: begin
            if (wrap3_c) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
      if (abort) begin
         state_nx = ST_IDLE;
         load_c   = 1'b0;
         err_c    = 1'b0;
      end
   end

   // Registered status outputs and the factor capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         fac       <= '0;
      end else begin
         idx_valid <= (state_nx == ST_RUN);
         busy      <= (state_nx == ST_LOAD) || (state_nx == ST_RUN);
         done      <= (state == ST_DONE) && !abort;
         cfg_err   <= err_c;
         if (load_c) begin
            fac.n1 <= CFG_W'(cfg_n1);
            fac.n2 <= CFG_W'(cfg_n2);
            fac.n3 <= CFG_W'(cfg_n3);
         end
      end
   end

endmodule

// File: tb/tb_pfa_seq_ctrl.sv
// Self-checking bench for pfa_seq_ctrl: tuple-list reference model, scenario table, random runs.
module tb_pfa_seq_ctrl;

   localparam int unsigned W = 10;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, abort, mode, ext_step, idx_ready;
   logic [W-1:0] cfg_n1, cfg_n2, cfg_n3;
   logic         idx_valid, idx_last, wrap1, wrap2, busy, done, cfg_err;
   logic [W-1:0] n1_out, n2_out, n3_out;

   pfa_seq_ctrl #(.IDX_W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .mode      (mode),
      .ext_step  (ext_step),
      .cfg_n1    (cfg_n1),
      .cfg_n2    (cfg_n2),
      .cfg_n3    (cfg_n3),
      .idx_ready (idx_ready),
      .idx_valid (idx_valid),
      .n1_out    (n1_out),
      .n2_out    (n2_out),
      .n3_out    (n3_out),
      .idx_last  (idx_last),
      .wrap1     (wrap1),
      .wrap2     (wrap2),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct { int n1; int n2; int n3; } tup_t;

   typedef struct {
      int a; int b; int c;
      bit md; int rdy; int per;
      int xfers; int w1; int w2;
   } vec_t;

   int   checks = 0;
   int   passed = 0;
   int   cyc_no = 0;

   // Reference model: list of tuples still to be delivered plus timing counters.
   tup_t q[$];
   bit   m_active = 1'b0;
   int   m_lat = 0;
   int   m_done_cnt = 0;
   bit   m_err = 1'b0;

   // Per-sequence observations of the DUT.
   int   seq_x, seq_w1, seq_w2, seq_d;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc_no, act, exp);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_idx_valid"}, int'(idx_valid), 0);
      chk({tag, "_n1"},        int'(n1_out),    0);
      chk({tag, "_n2"},        int'(n2_out),    0);
      chk({tag, "_n3"},        int'(n3_out),    0);
      chk({tag, "_idx_last"},  int'(idx_last),  0);
      chk({tag, "_wrap1"},     int'(wrap1),     0);
      chk({tag, "_wrap2"},     int'(wrap2),     0);
      chk({tag, "_busy"},      int'(busy),      0);
      chk({tag, "_done"},      int'(done),      0);
      chk({tag, "_cfg_err"},   int'(cfg_err),   0);
   endtask

   // One clock: sample and check at the falling edge, advance the model, move past the rising edge.
   task automatic tick();
      bit ev, xf, el, w1, w2, idle_now;
      int e1, e2, e3;
      @(negedge clk);
      cyc_no++;
      ev = m_active && (m_lat == 0);
      xf = ev && idx_ready && (!mode || ext_step) && !abort;
      e1 = 0; e2 = 0; e3 = 0; el = 1'b0; w1 = 1'b0; w2 = 1'b0;
      if (ev) begin
         e1 = q[0].n1; e2 = q[0].n2; e3 = q[0].n3;
         el = (q.size() == 1);
         w1 = xf && ((q.size() == 1) || (q[1].n1 == 0));
         w2 = w1 && ((q.size() == 1) || (q[1].n3 != q[0].n3));
      end
      chk("idx_valid", int'(idx_valid), int'(ev));
      chk("busy",      int'(busy),      int'(m_active));
      chk("done",      int'(done),      int'(m_done_cnt == 1));
      chk("cfg_err",   int'(cfg_err),   int'(m_err));
      chk("n1_out",    int'(n1_out),    e1);
      chk("n2_out",    int'(n2_out),    e2);
      chk("n3_out",    int'(n3_out),    e3);
      chk("idx_last",  int'(idx_last),  int'(el));
      chk("wrap1",     int'(wrap1),     int'(w1));
      chk("wrap2",     int'(wrap2),     int'(w2));
      if (idx_valid && idx_ready && (!mode || ext_step) && !abort) seq_x++;
      seq_w1 += int'(wrap1);
      seq_w2 += int'(wrap2);
      seq_d  += int'(done);

      idle_now = !m_active && (m_done_cnt != 2);
      if (m_done_cnt > 0) m_done_cnt--;
      m_err = 1'b0;
      if (abort) begin
         m_active = 1'b0;
         q.delete();
         m_done_cnt = 0;
      end else if (idle_now && start) begin
         if (int'(cfg_n1) == 0 || int'(cfg_n2) == 0 || int'(cfg_n3) == 0) begin
            m_err = 1'b1;
         end else begin
            q.delete();
            for (int k = 0; k < int'(cfg_n3); k++)
               for (int j = 0; j < int'(cfg_n2); j++)
                  for (int i = 0; i < int'(cfg_n1); i++)
                     q.push_back('{i, j, k});
            m_active = 1'b1;
            m_lat = 1;
         end
      end else if (m_active) begin
         if (m_lat > 0) begin
            m_lat--;
         end else if (xf) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
               m_active = 1'b0;
               m_done_cnt = 2;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Start one sequence and drive it until done or abort.
   // rdy: 0 always ready, 1 toggling, 2 random. per: ext_step period, 0 = random.
   task automatic run_seq(input int a, input int b, input int c, input bit md,
                          input int rdy, input int per, input int abort_at, input bit rnd_abort);
      bit ab;
      seq_x = 0; seq_w1 = 0; seq_w2 = 0; seq_d = 0; ab = 1'b0;
      mode = md;
      cfg_n1 = W'(a); cfg_n2 = W'(b); cfg_n3 = W'(c);
      start = 1'b1; abort = 1'b0; idx_ready = 1'b1; ext_step = 1'b0;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         case (rdy)
            0:       idx_ready = 1'b1;
            1:       idx_ready = (k % 2 == 0);
            default: idx_ready = 1'($urandom_range(0, 1));
         endcase
         ext_step = (per > 0) ? (k % per == per - 1) : 1'($urandom_range(0, 1));
         cfg_n1 = W'($urandom); cfg_n2 = W'($urandom); cfg_n3 = W'($urandom);
         start = m_active ? ($urandom_range(0, 3) == 0) : 1'b0;
         abort = 1'b0;
         if (abort_at >= 0 && seq_x == abort_at) begin
            abort = 1'b1; start = 1'b1; idx_ready = 1'b1;
         end
         if (rnd_abort && $urandom_range(0, 99) == 0) abort = 1'b1;
         ab = abort;
         tick();
         abort = 1'b0; start = 1'b0;
         if (ab || seq_d > 0) break;
      end
      chk("seq_done_pulses", seq_d, ab ? 0 : 1);
   endtask

   vec_t tbl[5];

   initial begin
      rst_n = 1'b0;
      start = 1'b0; abort = 1'b0; mode = 1'b0; ext_step = 1'b0; idx_ready = 1'b0;
      cfg_n1 = '0; cfg_n2 = '0; cfg_n3 = '0;

      tbl[0] = '{a:3, b:2, c:2, md:1'b0, rdy:0, per:0, xfers:12,  w1:4,  w2:2};
      tbl[1] = '{a:4, b:3, c:1, md:1'b0, rdy:1, per:0, xfers:12,  w1:3,  w2:1};
      tbl[2] = '{a:2, b:2, c:1, md:1'b1, rdy:0, per:3, xfers:4,   w1:2,  w2:1};
      tbl[3] = '{a:1, b:1, c:1, md:1'b0, rdy:0, per:0, xfers:1,   w1:1,  w2:1};
      tbl[4] = '{a:5, b:5, c:5, md:1'b0, rdy:2, per:0, xfers:125, w1:25, w2:5};

      #12;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (2) tick();

      // Scenario table: totals per sequence; ordering and timing via the model.
      for (int i = 0; i < 5; i++) begin
         run_seq(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].md, tbl[i].rdy, tbl[i].per, -1, 1'b0);
         chk("tbl_xfers", seq_x,  tbl[i].xfers);
         chk("tbl_wrap1", seq_w1, tbl[i].w1);
         chk("tbl_wrap2", seq_w2, tbl[i].w2);
         tick();
      end

      // Rejected starts: any zero factor.
      for (int i = 0; i < 3; i++) begin
         cfg_n1 = W'(3); cfg_n2 = W'(2); cfg_n3 = W'(2);
         if (i == 0) cfg_n2 = '0;
         if (i == 1) cfg_n1 = '0;
         if (i == 2) cfg_n3 = '0;
         start = 1'b1;
         tick();
         start = 1'b0;
         chk("err_pulse", int'(cfg_err), 1);
         tick();
         tick();
      end

      // Abort after 7 transfers, together with start and ready, then a fresh run.
      run_seq(5, 5, 5, 1'b0, 0, 0, 7, 1'b0);
      chk("abort_xfers", seq_x, 7);
      chk_zero("post_abort");
      repeat (3) tick();
      run_seq(2, 3, 1, 1'b0, 0, 0, -1, 1'b0);
      chk("rerun_xfers", seq_x, 6);

      // Reset in the middle of a sequence: immediate clear, no done afterwards.
      mode = 1'b0; idx_ready = 1'b1;
      cfg_n1 = W'(3); cfg_n2 = W'(3); cfg_n3 = W'(3);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("rst_mid");
      m_active = 1'b0; q.delete(); m_done_cnt = 0; m_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      seq_d = 0;
      repeat (5) tick();
      chk("rst_no_done", seq_d, 0);

      // Random factors, modes, handshakes and occasional aborts.
      for (int r = 0; r < 25; r++) begin
         run_seq(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                 1'($urandom_range(0, 1)), 2, 0, -1, 1'b1);
         repeat (int'($urandom_range(0, 2))) tick();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/pfa_seq_ctrl.md
PFA_SEQ_CTRL -- requirements
Module: pfa_seq_ctrl

Interface
REQ-001 Parameter IDX_W, default 10: width of every index and factor field.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  start request; one-cycle pulse or level, sampled only in IDLE.
REQ-005 abort  input  1  synchronous abort of the current sequence.
REQ-006 mode  input  1  0 = free-running inner step; 1 = inner step gated by ext_step.
REQ-007 ext_step  input  1  external step qualifier, used only when mode=1.
REQ-008 cfg_n1, cfg_n2, cfg_n3  input  IDX_W each  factor sizes, n1 innermost; sampled on accepted start.
REQ-009 idx_ready  input  1  downstream ready.
REQ-010 idx_valid  output  1  index tuple valid.
REQ-011 n1_out, n2_out, n3_out  output  IDX_W each  current index tuple.
REQ-012 idx_last  output  1  marks the final tuple (cfg_n1-1, cfg_n2-1, cfg_n3-1).
REQ-013 wrap1, wrap2  output  1 each  inner / middle counter wrap, qualified by the transfer.
REQ-014 busy  output  1  high in LOAD and RUN.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 cfg_err  output  1  one-cycle pulse when start is rejected.

Function
REQ-017 FSM states: IDLE, LOAD, RUN, DONE; encoding is free.
REQ-018 IDLE -> LOAD on start with all cfg_n* nonzero; the factors are registered in this transition.
REQ-019 If start arrives in IDLE with any cfg_n* = 0: pulse cfg_err for one cycle and remain in IDLE.
REQ-020 LOAD -> RUN after one cycle; counters = 0 and idx_valid = 1 in the first RUN cycle (start at cycle t gives first valid tuple at t+2).
REQ-021 Transfer condition: idx_valid and idx_ready, and additionally ext_step when mode=1.
REQ-022 Without a transfer, all outputs hold stable.
REQ-023 On transfer, n1 increments; at n1 = N1-1 it wraps to 0, wrap1 = 1 and n2 increments.
REQ-024 n2 wraps likewise at N2-1, asserting wrap2 and incrementing n3.
REQ-025 A factor of 1 keeps its counter at 0 and asserts its wrap on every carry into it.
REQ-026 Comparisons use the full IDX_W width; there is no overflow, since counters never exceed N-1.
REQ-027 idx_last is combinational from the counters and registered factors, and is valid only while idx_valid = 1.
REQ-028 A transfer with idx_last = 1: RUN -> DONE, idx_valid = 0 in the next cycle.
REQ-029 DONE pulses done for one cycle, then returns to IDLE.
REQ-030 Exactly cfg_n1*cfg_n2*cfg_n3 transfers occur per sequence.
REQ-031 abort high in any state: next cycle IDLE, counters cleared, idx_valid = 0, no done pulse.
REQ-032 abort has priority over start and over any transfer in the same cycle.
REQ-033 start outside IDLE is ignored; the cfg_n* inputs may change freely after acceptance.
REQ-034 ext_step while idx_ready = 0 is lost; the controller does not buffer steps.

Reset
REQ-035 Reset clears all outputs to 0: idx_valid, n*_out, idx_last, wrap1, wrap2, busy, done, cfg_err.
REQ-036 Reset puts the FSM in IDLE and clears the registered factors to 0.
REQ-037 Reset asserted mid-sequence aborts immediately; no done pulse follows deassertion.

Structure
REQ-038 A shared package holds IDX_W, the FSM state enum and a factor-config struct {n1, n2, n3}.
REQ-039 One sub-module, pfa_idx_cnt, is instantiated three times: a wrapping counter with inputs inc and limit, outputs count and wrap; n1/n2/n3 chain through wrap.

Verification
REQ-040 cfg (3,2,2), mode=0, ready=1: 12 tuples in order (0,0,0),(1,0,0),(2,0,0),(0,1,0)...(2,1,1); idx_last on the 12th; done exactly 2 cycles after the last transfer; wrap1 4 times, wrap2 2 times.
REQ-041 cfg (4,3,1), ready toggled 1,0,1,0...: tuples held stable during ready=0; 12 transfers total; no duplicates or skips.
REQ-042 mode=1, cfg (2,2,1), ext_step every 3rd cycle: exactly one advance per ext_step; 4 tuples; done after the 4th.
REQ-043 start with cfg_n2 = 0: cfg_err pulses once, busy stays 0, idx_valid stays 0.
REQ-044 cfg (5,5,5); abort asserted after 7 transfers together with start and ready: IDLE next cycle, outputs 0, no done; a fresh start then begins again at (0,0,0).
REQ-045 cfg (1,1,1): a single tuple (0,0,0) with idx_last = 1, wrap1 = wrap2 = 1, then done.
